// File: rtl/operand_deserializer_pkg.sv
// Shared types, helpers and constants for the operand deserializer slice.
// Optional feature macro used by the top module: OPERAND_DESER_LAST_EN.
package operand_pkg;

   localparam int unsigned DEFAULT_DATAW = 8;

   typedef logic [DEFAULT_DATAW-1:0] element_t;

   function automatic int unsigned beats(input int unsigned num_inputs,
                                         input int unsigned lanes);
      return num_inputs / lanes;
   endfunction

   function automatic bit is_pow2(input int unsigned x);
      return (x != 0) && ((x & (x - 1)) == 0);
   endfunction

endpackage

// File: rtl/operand_deserializer_out_reg.sv
// One-entry valid/ready holding register for an assembled vector plus its sign flag.
module vector_out_reg
   import operand_pkg::*;
#(
   parameter int unsigned NUM_INPUTS = 16,
   parameter int unsigned DATAW      = 8
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic                              load_valid_i,
   output logic                              load_ready_o,
   input  logic [NUM_INPUTS-1:0][DATAW-1:0]  load_data_i,
   input  logic                              load_sign_i,
   output logic                              out_valid_o,
   input  logic                              out_ready_i,
   output logic [NUM_INPUTS-1:0][DATAW-1:0]  out_data_o,
   output logic                              out_sign_o
);

   // Accepting while draining keeps out_valid_o high with no bubble.
   assign load_ready_o = !out_valid_o || out_ready_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         out_valid_o <= 1'b0;
         out_data_o  <= '0;
         out_sign_o  <= 1'b0;
      end else if (load_valid_i && load_ready_o) begin
         out_valid_o <= 1'b1;
         out_data_o  <= load_data_i;
         out_sign_o  <= load_sign_i;
      end else if (out_ready_i) begin
         out_valid_o <= 1'b0;
      end
   end

endmodule

// File: rtl/operand_deserializer.sv
// Gathers LANES-wide operand beats into a NUM_INPUTS vector for the adder tree.
// Define OPERAND_DESER_LAST_EN to let in_last_i end a vector early (zero-filled).
module operand_deserializer
   import operand_pkg::*;
#(
   parameter int unsigned NUM_INPUTS = 16,
   parameter int unsigned DATAW      = 8,
   parameter int unsigned LANES      = 4
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic                              in_valid_i,
   output logic                              in_ready_o,
   input  logic [LANES-1:0][DATAW-1:0]       in_data_i,
   input  logic                              in_sign_unsign_ni,
   input  logic                              in_last_i,
   output logic                              out_valid_o,
   input  logic                              out_ready_i,
   output logic [NUM_INPUTS-1:0][DATAW-1:0]  out_data_o,
   output logic                              out_sign_unsign_no
);

   localparam int unsigned BEATS = beats(NUM_INPUTS, LANES);
   localparam int unsigned CNTW  = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CNTW-1:0] LAST_CNT = CNTW'(BEATS - 1);

   if (!is_pow2(NUM_INPUTS)) begin : g_bad_num_inputs
      $error("NUM_INPUTS must be a power of 2");
   end
   if (!is_pow2(LANES) || (LANES > NUM_INPUTS)) begin : g_bad_lanes
      $error("LANES must be a power of 2 and not exceed NUM_INPUTS");
   end

   typedef enum logic {FILL, HOLD} state_t;

   state_t                           state;
   logic [CNTW-1:0]                  cnt;
   logic [NUM_INPUTS-1:0][DATAW-1:0] fill_buf;
   logic [NUM_INPUTS-1:0][DATAW-1:0] fill_next;
   logic [NUM_INPUTS-1:0][DATAW-1:0] load_data;
   logic                             fill_sign;
   logic                             fill_sign_next;
   logic                             load_sign;
   logic                             accept;
   logic                             last_beat;
   logic                             complete;
   logic                             load_valid;
   logic                             load_ready;

`ifndef OPERAND_DESER_LAST_EN
   logic unused_last;
   assign unused_last = in_last_i;
`endif

   always_comb begin
      accept = in_valid_i && in_ready_o;
`ifdef OPERAND_DESER_LAST_EN
      last_beat = (cnt == LAST_CNT) || in_last_i;
`else
      last_beat = (cnt == LAST_CNT);
`endif
      complete       = accept && last_beat;
      fill_sign_next = (cnt == '0) ? in_sign_unsign_ni : fill_sign;

      fill_next = fill_buf;
      for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
         if (CNTW'(i / LANES) == cnt) fill_next[i] = in_data_i[i % LANES];
`ifdef OPERAND_DESER_LAST_EN
         if (in_last_i && ((i / LANES) > 32'(cnt))) fill_next[i] = '0;
`endif
      end

      // In HOLD the completed vector already sits in fill_buf; in FILL it is
      // forwarded straight from the completing beat.
      load_valid = (state == HOLD) || complete;
      load_data  = (state == HOLD) ? fill_buf  : fill_next;
      load_sign  = (state == HOLD) ? fill_sign : fill_sign_next;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state      <= FILL;
         in_ready_o <= 1'b1;
         cnt        <= '0;
         fill_buf   <= '0;
         fill_sign  <= 1'b0;
      end else begin
         case (state)
            FILL: begin
               if (accept) begin
                  fill_buf  <= fill_next;
                  fill_sign <= fill_sign_next;
                  if (last_beat) begin
                     cnt <= '0;
                     if (!load_ready) begin
                        state      <= HOLD;
                        in_ready_o <= 1'b0;
                     end
                  end else begin
                     cnt <= cnt + CNTW'(1);
                  end
               end
            end
            HOLD: begin
               if (load_ready) begin
                  state      <= FILL;
                  in_ready_o <= 1'b1;
               end
            end
            default: begin
               state      <= FILL;
               in_ready_o <= 1'b1;
            end
         endcase
      end
   end

   vector_out_reg #(
      .NUM_INPUTS (NUM_INPUTS),
      .DATAW      (DATAW)
   ) u_out_reg (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .load_valid_i (load_valid),
      .load_ready_o (load_ready),
      .load_data_i  (load_data),
      .load_sign_i  (load_sign),
      .out_valid_o  (out_valid_o),
      .out_ready_i  (out_ready_i),
      .out_data_o   (out_data_o),
      .out_sign_o   (out_sign_unsign_no)
   );

endmodule

// File: tb/tb_operand_deserializer.sv
// Scoreboard bench for operand_deserializer (NUM_INPUTS=8, LANES=2, DATAW=8).
module tb_operand_deserializer;

   localparam int unsigned NI  = 8;
   localparam int unsigned L   = 2;
   localparam int unsigned DW  = 8;
   localparam int unsigned VW  = NI * DW;

   typedef struct {
      logic [VW-1:0] data;
      logic          sign;
   } exp_t;

   logic                 clk = 1'b0;
   logic                 rst_i = 1'b1;
   logic                 in_valid_i = 1'b0;
   logic                 in_ready_o;
   logic [L-1:0][DW-1:0] in_data_i = '0;
   logic                 in_sign_unsign_ni = 1'b0;
   logic                 in_last_i = 1'b0;
   logic                 out_valid_o;
   logic                 out_ready_i = 1'b0;
   logic [NI-1:0][DW-1:0] out_data_o;
   logic                 out_sign_unsign_no;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   last_acc_cyc = 0;
   bit   rand_ready = 1'b0;

   logic [DW-1:0] cur_elems[$];
   logic          cur_sign;
   exp_t          exp_q[$];

   operand_deserializer #(
      .NUM_INPUTS (NI),
      .DATAW      (DW),
      .LANES      (L)
   ) dut (
      .clk_i              (clk),
      .rst_i              (rst_i),
      .in_valid_i         (in_valid_i),
      .in_ready_o         (in_ready_o),
      .in_data_i          (in_data_i),
      .in_sign_unsign_ni  (in_sign_unsign_ni),
      .in_last_i          (in_last_i),
      .out_valid_o        (out_valid_o),
      .out_ready_i        (out_ready_i),
      .out_data_o         (out_data_o),
      .out_sign_unsign_no (out_sign_unsign_no)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [VW-1:0] got, input logic [VW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   // Reference model: collect elements, emit a vector on BEATS beats (or early last).
   function automatic void model_beat(input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                                      input logic s, input logic l);
      bit   done;
      exp_t e;
      if (cur_elems.size() == 0) cur_sign = s;
      cur_elems.push_back(d0);
      cur_elems.push_back(d1);
      done = (cur_elems.size() == NI);
`ifdef OPERAND_DESER_LAST_EN
      done = done || l;
`else
      if (l) done = done;
`endif
      if (done) begin
         e.data = '0;
         for (int i = 0; i < cur_elems.size(); i++) e.data[i*DW +: DW] = cur_elems[i];
         e.sign = cur_sign;
         exp_q.push_back(e);
         cur_elems.delete();
      end
   endfunction

   // Monitor: every handshake on the output pops one expected vector.
   always @(negedge clk) begin
      if (!rst_i && out_valid_o && out_ready_i) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output got=%h exp=none", out_data_o);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("out_data", out_data_o, e.data);
            check("out_sign", VW'(out_sign_unsign_no), VW'(e.sign));
         end
      end
   end

   task automatic send_beat(input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                            input logic s, input logic l);
      bit ok = 1'b0;
      in_valid_i        = 1'b1;
      in_data_i[0]      = d0;
      in_data_i[1]      = d1;
      in_sign_unsign_ni = s;
      in_last_i         = l;
      for (int n = 0; n < 500; n++) begin
         @(negedge clk);
         if (in_ready_o) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
         if (rand_ready) out_ready_i = 1'($urandom_range(0, 1));
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL beat_timeout got=in_ready_low exp=accept");
         in_valid_i = 1'b0;
         return;
      end
      model_beat(d0, d1, s, l);
      last_acc_cyc = cyc;
      @(posedge clk);
      #1;
      in_valid_i = 1'b0;
      in_last_i  = 1'b0;
      if (rand_ready) out_ready_i = 1'($urandom_range(0, 1));
   endtask

   task automatic drain();
      out_ready_i = 1'b1;
      for (int n = 0; n < 200; n++) begin
         if (exp_q.size() == 0) break;
         @(posedge clk);
         #2;
      end
      check("drain_empty", VW'(exp_q.size()), '0);
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      in_valid_i = 1'b0;
      cur_elems.delete();
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_i = 1'b0;
   endtask

   initial begin
      int first_cyc;
      #2_000_000;
      $display("FAIL watchdog got=hang exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int first_cyc;
      repeat (3) @(posedge clk);
      #1;
      rst_i = 1'b0;
      @(negedge clk);
      check("rst_out_valid", VW'(out_valid_o), '0);
      check("rst_in_ready", VW'(in_ready_o), VW'(1));
      check("rst_out_data", out_data_o, '0);
      check("rst_out_sign", VW'(out_sign_unsign_no), '0);
      @(posedge clk);
      #1;

      // 1: basic vector, latency one cycle, valid for one cycle
      out_ready_i = 1'b1;
      send_beat(8'd1, 8'd2, 1'b1, 1'b0);
      send_beat(8'd3, 8'd4, 1'b0, 1'b0);
      send_beat(8'd5, 8'd6, 1'b0, 1'b0);
      send_beat(8'd7, 8'd8, 1'b0, 1'b0);
      @(negedge clk);
      check("t1_latency_valid", VW'(out_valid_o), VW'(1));
      check("t1_data", out_data_o, 64'h0807060504030201);
      @(negedge clk);
      check("t1_valid_drop", VW'(out_valid_o), '0);
      @(posedge clk);
      #1;

      // 2: two vectors with stalled consumer, then drain in order
      out_ready_i = 1'b0;
      for (int b = 0; b < 8; b++)
         send_beat(8'(8'h10 + 2*b), 8'(8'h11 + 2*b), (b >= 4), 1'b0);
      repeat (3) begin
         @(negedge clk);
         check("t2_hold_in_ready", VW'(in_ready_o), '0);
         check("t2_hold_valid", VW'(out_valid_o), VW'(1));
         check("t2_hold_stable", out_data_o, exp_q[0].data);
      end
      @(posedge clk);
      #1;
      drain();

      // 3: 5 vectors streamed; sign flips after beat 0 are ignored
      out_ready_i = 1'b1;
      first_cyc = -1;
      for (int b = 0; b < 20; b++) begin
         send_beat(8'($urandom), 8'($urandom), ((b % 4) == 0) ? 1'(b / 4 % 2) : 1'($urandom), 1'b0);
         if (first_cyc < 0) first_cyc = last_acc_cyc;
      end
      check("t3_throughput", VW'(last_acc_cyc - first_cyc), VW'(19));
      drain();

      // 4: reset drops a held vector and a partial one
      out_ready_i = 1'b0;
      for (int b = 0; b < 6; b++) send_beat(8'($urandom), 8'($urandom), 1'b1, 1'b0);
      do_reset();
      out_ready_i = 1'b1;
      @(negedge clk);
      check("t4_rst_valid", VW'(out_valid_o), '0);
      check("t4_rst_in_ready", VW'(in_ready_o), VW'(1));
      @(posedge clk);
      #1;
      for (int b = 0; b < 4; b++) send_beat(8'(9 + 2*b), 8'(10 + 2*b), 1'b0, 1'b0);
      drain();

      // 5: early last (only honoured with the feature macro)
      send_beat(8'd1, 8'd2, 1'b1, 1'b0);
      send_beat(8'd3, 8'd4, 1'b0, 1'b1);
`ifdef OPERAND_DESER_LAST_EN
      check("t5_early_pending", VW'(exp_q.size()), VW'(1));
`else
      check("t5_no_early", VW'(exp_q.size()), '0);
      send_beat(8'd5, 8'd6, 1'b0, 1'b0);
      send_beat(8'd7, 8'd8, 1'b0, 1'b0);
`endif
      drain();

      // 6: drain of A coincides with completing beat of B
      out_ready_i = 1'b0;
      for (int b = 0; b < 7; b++) send_beat(8'(8'h40 + b), 8'(8'h80 + b), 1'b0, 1'b0);
      out_ready_i = 1'b1;
      send_beat(8'h47, 8'h87, 1'b0, 1'b0);
      @(negedge clk);
      check("t6_no_bubble", VW'(out_valid_o), VW'(1));
      @(posedge clk);
      #1;
      drain();

      // Random traffic with random consumer back-pressure
      rand_ready = 1'b1;
      for (int b = 0; b < 160; b++) begin
         send_beat(8'($urandom), 8'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0));
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
            out_ready_i = 1'($urandom_range(0, 1));
         end
      end
      rand_ready = 1'b0;
      // Flush any partial vector with full beats so the model and DUT line up.
      while (cur_elems.size() != 0) send_beat(8'($urandom), 8'($urandom), 1'b0, 1'b0);
      drain();
      @(negedge clk);
      check("final_idle", VW'(out_valid_o), '0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
